// File: rtl/spi_omega_rx_pkg.sv
// Shared constants and state encoding for the omega SPI receiver.
package spi_omega_rx_pkg;

    localparam int WORD_W_DEF  = 40;
    localparam int FRAME_CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

endpackage

// File: rtl/spi_omega_rx_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall detection.
// Edges are held off until both the synchronized level and its delayed copy
// carry real pin samples, so reset values never look like a pin transition.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   prime_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1];

    // Synchronizer chain, edge-detect flop and registered edge pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= {SYNC_STAGES{RST_VAL}};
            prime_q <= '0;
            prev_q  <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
            prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
            prev_q  <= level;
            rise_q  <= prime_q[SYNC_STAGES] & level & ~prev_q;
            fall_q  <= prime_q[SYNC_STAGES] & ~level & prev_q;
        end
    end

    assign level_o = level;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_omega_rx.sv
// SPI mode-0 slave receiving an MSB-first frequency word into the CLK67MHZ
// domain; the output word only moves on a frame of exactly WORD_W bits.
module spi_omega_rx
    import spi_omega_rx_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   CLK67MHZ,
    input  logic                   resetPort,
    input  logic                   sckPort,
    input  logic                   mosiPort,
    input  logic                   sselPort,
    output logic [WORD_W-1:0]      omega_out,
    output logic                   omega_valid,
    output logic                   frame_err,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int CNT_W = $clog2(WORD_W + 2);

    logic sck_rise, sck_fall_unused, sck_lvl_unused;
    logic ssel_rise, ssel_fall, ssel_lvl_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk_i(CLK67MHZ), .rst_i(resetPort), .d_i(sckPort),
        .level_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall_unused)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ssel (
        .clk_i(CLK67MHZ), .rst_i(resetPort), .d_i(sselPort),
        .level_o(ssel_lvl_unused), .rise_o(ssel_rise), .fall_o(ssel_fall)
    );

    // One extra stage beyond the synchronizer matches the registered edge pulse.
    logic [SYNC_STAGES:0] mosi_q;
    logic                 mosi_bit;
    assign mosi_bit = mosi_q[SYNC_STAGES];

    // MOSI delay chain aligned to the sck_rise pulse.
    always_ff @(posedge CLK67MHZ or posedge resetPort) begin
        if (resetPort) mosi_q <= '0;
        else           mosi_q <= {mosi_q[SYNC_STAGES-1:0], mosiPort};
    end

    state_e                 state_q, state_d;
    logic [WORD_W-1:0]      shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WORD_W-1:0]      omega_q, omega_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;

    // Frame state and output registers.
    always_ff @(posedge CLK67MHZ or posedge resetPort) begin
        if (resetPort) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            omega_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            omega_q <= omega_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next state: ssel_rise takes priority over a coincident sck_rise, and the
    // counter parks at WORD_W+1 so overlong frames always end in an error.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        omega_d = omega_q;
        fcnt_d  = fcnt_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ssel_fall) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            RECV: begin
                if (ssel_rise) begin
                    state_d = IDLE;
                    if (cnt_q == CNT_W'(WORD_W)) begin
                        omega_d = shift_q;
                        valid_d = 1'b1;
                        fcnt_d  = fcnt_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sck_rise) begin
                    shift_d = {shift_q[WORD_W-2:0], mosi_bit};
                    if (cnt_q != CNT_W'(WORD_W + 1)) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign omega_out   = omega_q;
    assign omega_valid = valid_q;
    assign frame_err   = err_q;
    assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_spi_omega_rx.sv
// Directed bench for spi_omega_rx: latency, good/short/long frames, reset
// behaviour, counter wrap and SSEL-low-at-reset.
module tb_spi_omega_rx;

    logic        CLK67MHZ = 1'b0;
    logic        resetPort;
    logic        sckPort;
    logic        mosiPort;
    logic        sselPort;
    logic [39:0] omega_out;
    logic        omega_valid;
    logic        frame_err;
    logic [7:0]  frame_cnt;

    int nchecks = 0;
    int nerr    = 0;
    int vcnt    = 0;
    int ecnt    = 0;
    int both    = 0;

    spi_omega_rx #(.WORD_W(40), .SYNC_STAGES(2)) dut (
        .CLK67MHZ(CLK67MHZ), .resetPort(resetPort),
        .sckPort(sckPort), .mosiPort(mosiPort), .sselPort(sselPort),
        .omega_out(omega_out), .omega_valid(omega_valid),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 CLK67MHZ = ~CLK67MHZ;

    // Pulse tally sampled away from the active edge.
    always @(negedge CLK67MHZ) begin
        if (omega_valid) vcnt++;
        if (frame_err) ecnt++;
        if (omega_valid && frame_err) both++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK67MHZ);
    endtask

    // Drop SSEL and clock out nbits of data MSB first; SSEL is left low.
    task automatic send_bits(input logic [63:0] data, input int nbits, input int half);
        sselPort = 1'b0;
        wait_clk(half);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosiPort = data[i];
            wait_clk(half);
            sckPort = 1'b1;
            wait_clk(half);
            sckPort = 1'b0;
        end
        wait_clk(half);
    endtask

    // Raise SSEL; report activity 3 edges later and the outputs 4 edges later.
    task automatic end_frame(output logic early, output logic vat, output logic eat);
        sselPort = 1'b1;
        wait_clk(3);
        early = omega_valid | frame_err;
        wait_clk(1);
        vat = omega_valid;
        eat = frame_err;
    endtask

    initial begin
        logic early, vat, eat;
        int   v0, e0;

        resetPort = 1'b1;
        sselPort  = 1'b1;
        sckPort   = 1'b0;
        mosiPort  = 1'b0;
        wait_clk(3);
        chk("rst_omega", omega_out, 0);
        chk("rst_valid", omega_valid, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_cnt", frame_cnt, 0);
        resetPort = 1'b0;
        wait_clk(5);

        // Good frame, latency of SYNC_STAGES+2 edges from the SSEL rise
        v0 = vcnt; e0 = ecnt;
        send_bits(64'h12_3456_789A, 40, 4);
        end_frame(early, vat, eat);
        chk("lat_early", early, 0);
        chk("lat_valid", vat, 1);
        chk("lat_err", eat, 0);
        wait_clk(5);
        chk("t1_omega", omega_out, 40'h12_3456_789A);
        chk("t1_cnt", frame_cnt, 1);
        chk("t1_vpulses", vcnt - v0, 1);
        chk("t1_epulses", ecnt - e0, 0);

        // Valid 1, then a 39-bit frame
        send_bits(64'h1, 40, 4);
        end_frame(early, vat, eat);
        wait_clk(5);
        chk("t2_omega1", omega_out, 40'h1);
        chk("t2_cnt1", frame_cnt, 2);
        v0 = vcnt; e0 = ecnt;
        send_bits(64'hFF_FFFF_FFFF, 39, 4);
        end_frame(early, vat, eat);
        chk("t2_short_err", eat, 1);
        chk("t2_short_vld", vat, 0);
        wait_clk(5);
        chk("t2_omega", omega_out, 40'h1);
        chk("t2_cnt", frame_cnt, 2);
        chk("t2_epulses", ecnt - e0, 1);

        // 41-bit frame
        v0 = vcnt; e0 = ecnt;
        send_bits(64'h1_2345_6789_AB, 41, 4);
        end_frame(early, vat, eat);
        chk("t3_long_err", eat, 1);
        chk("t3_long_vld", vat, 0);
        wait_clk(5);
        chk("t3_omega", omega_out, 40'h1);
        chk("t3_cnt", frame_cnt, 2);
        chk("t3_vpulses", vcnt - v0, 0);

        // Reset after 20 bits, then a full frame
        send_bits(64'hA_BCDE, 20, 4);
        v0 = vcnt; e0 = ecnt;
        resetPort = 1'b1;
        sselPort  = 1'b1;
        wait_clk(3);
        chk("t4_rst_omega", omega_out, 0);
        chk("t4_rst_valid", omega_valid, 0);
        chk("t4_rst_err", frame_err, 0);
        chk("t4_rst_cnt", frame_cnt, 0);
        resetPort = 1'b0;
        wait_clk(5);
        chk("t4_rst_pulses", (vcnt - v0) + (ecnt - e0), 0);
        send_bits(64'hFF_FFFF_FFFF, 40, 4);
        end_frame(early, vat, eat);
        chk("t4_valid", vat, 1);
        wait_clk(5);
        chk("t4_omega", omega_out, 40'hFF_FFFF_FFFF);
        chk("t4_cnt", frame_cnt, 1);

        // SSEL held low through reset release
        resetPort = 1'b1;
        sselPort  = 1'b0;
        wait_clk(3);
        resetPort = 1'b0;
        v0 = vcnt; e0 = ecnt;
        wait_clk(5);
        send_bits(64'h12_3456_789A, 40, 4);
        sselPort = 1'b1;
        wait_clk(10);
        chk("t6_vpulses", vcnt - v0, 0);
        chk("t6_epulses", ecnt - e0, 0);
        chk("t6_omega", omega_out, 0);
        chk("t6_cnt", frame_cnt, 0);

        // 256 back-to-back frames with 3-clock SSEL gaps
        v0 = vcnt; e0 = ecnt;
        for (int k = 0; k < 256; k++) begin
            send_bits((k % 2 == 0) ? 64'hAA_AAAA_AAAA : 64'h55_5555_5555, 40, 3);
            sselPort = 1'b1;
            wait_clk(3);
        end
        wait_clk(10);
        chk("t5_vpulses", vcnt - v0, 256);
        chk("t5_epulses", ecnt - e0, 0);
        chk("t5_cnt_wrap", frame_cnt, 0);
        chk("t5_omega", omega_out, 40'h55_5555_5555);

        chk("never_both", both, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
